// File: rtl/eq_band_ctrl_pkg.sv
// Shared types and constants for the equalizer user-control block.
// Latency: n/a (types, constants and one pure combinational helper).
// Backpressure: n/a.
package eq_band_ctrl_pkg;

   // State encoding is visible on o_state, so the values are fixed constants.
   typedef logic [2:0] state_t;
   localparam state_t S_INIT     = 3'd0;
   localparam state_t S_IDLE     = 3'd1;
   localparam state_t S_BAND_SEL = 3'd2;
   localparam state_t S_SET_GAIN = 3'd3;
   localparam state_t S_FLAT     = 3'd4;

   // Key event bit positions; a lower index has higher priority.
   localparam int KEY_BACK   = 0;
   localparam int KEY_SELECT = 1;
   localparam int KEY_UP     = 2;
   localparam int KEY_DOWN   = 3;

   // Keep only the highest-priority (lowest-index) event of the cycle.
   function automatic logic [3:0] first_key(input logic [3:0] ev);
      return ev & (~ev + 4'd1);
   endfunction

endpackage

// File: rtl/eq_band_ctrl_key_repeat.sv
// Key event generator: rising-edge event plus auto-repeat while held.
// Latency: event is combinational from key_i in the press cycle; repeats are counter timed.
// Backpressure: none; events are single-cycle pulses and are lost if the consumer ignores them.
// Ports: clk_i, rst_ni (async active-low), key_i (debounced level), evt_o (1-cycle event).
module eq_band_ctrl_key_repeat #(
   parameter logic [15:0] RPT_DLY = 16'd50000,
   parameter logic [15:0] RPT_PER = 16'd10000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic key_i,
   output logic evt_o
);

   logic        key_q;
   logic        rep_q, rep_d;
   logic [15:0] cnt_q, cnt_d;
   logic        rise, held, fire;

   // cnt_q holds the number of cycles since the last event while the key stays down;
   // rep_q selects between the initial delay and the repeat period.
   always_comb begin
      rise  = key_i & ~key_q;
      held  = key_i & key_q;
      fire  = held && (cnt_q == (rep_q ? RPT_PER : RPT_DLY));
      cnt_d = 16'd0;
      rep_d = 1'b0;
      if (rise) begin
         cnt_d = 16'd1;
      end else if (fire) begin
         cnt_d = 16'd1;
         rep_d = 1'b1;
      end else if (held) begin
         cnt_d = cnt_q + 16'd1;
         rep_d = rep_q;
      end
   end

   assign evt_o = rise | fire;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         key_q <= 1'b0;
         rep_q <= 1'b0;
         cnt_q <= 16'd0;
      end else begin
         key_q <= key_i;
         rep_q <= rep_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/eq_band_ctrl.sv
// User-control FSM for the N-band equalizer: codec init, band select, gain adjust, flat reset.
// Latency: a key event updates state/band/gain and loads the DSP update register on the next edge.
// Backpressure: while o_upd_valid is high, gain steps are dropped (never queued) until i_upd_ready.
// Ports: i_clk, i_rst_n, keys i_select/i_back/i_up/i_down, init o_init_start/i_init_done,
//        view o_state/o_band/o_gain, DSP update o_upd_valid/o_upd_band/o_upd_gain/i_upd_ready.
module eq_band_ctrl
   import eq_band_ctrl_pkg::*;
#(
   parameter int          NBAND     = 6,
   parameter int          GW        = 8,
   parameter int          GMAX      = 12,
   parameter logic [15:0] RPT_DLY   = 16'd50000,
   parameter logic [15:0] RPT_PER   = 16'd10000,
   parameter logic [23:0] FLAT_HOLD = 24'd200000,
   parameter bit          BAND_WRAP = 1'b0,
   localparam int         BW        = $clog2(NBAND)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_select,
   input  logic          i_back,
   input  logic          i_up,
   input  logic          i_down,
   output logic          o_init_start,
   input  logic          i_init_done,
   output logic [2:0]    o_state,
   output logic [BW-1:0] o_band,
   output logic [GW-1:0] o_gain,
   output logic          o_upd_valid,
   output logic [BW-1:0] o_upd_band,
   output logic [GW-1:0] o_upd_gain,
   input  logic          i_upd_ready
);

   typedef logic signed [GW-1:0] gain_t;

   localparam int            FW        = $clog2(NBAND + 1);
   localparam gain_t         G_MAX     = gain_t'(GMAX);
   localparam gain_t         G_MIN     = gain_t'(-GMAX);
   localparam logic [BW-1:0] BAND_LAST = BW'(NBAND - 1);
   localparam logic [FW-1:0] FLAT_END  = FW'(NBAND);

   state_t        state_q, state_d;
   logic [BW-1:0] band_q, band_d;
   gain_t         gain_q [NBAND];
   gain_t         gain_d [NBAND];
   logic          upd_vld_q, upd_vld_d;
   logic [BW-1:0] upd_band_q, upd_band_d;
   gain_t         upd_gain_q, upd_gain_d;
   logic          sel_q, back_q;
   logic [23:0]   hold_q, hold_d;
   logic [FW-1:0] flat_cnt_q, flat_cnt_d;

   logic          up_evt, dn_evt;
   logic [3:0]    key_raw, key_evt;
   logic          hold_run, flat_go;
   gain_t         cur_gain;

   eq_band_ctrl_key_repeat #(.RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER)) u_rpt_up (
      .clk_i (i_clk), .rst_ni(i_rst_n), .key_i(i_up),   .evt_o(up_evt)
   );
   eq_band_ctrl_key_repeat #(.RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER)) u_rpt_dn (
      .clk_i (i_clk), .rst_ni(i_rst_n), .key_i(i_down), .evt_o(dn_evt)
   );

   always_comb begin
      key_raw             = 4'd0;
      key_raw[KEY_BACK]   = i_back & ~back_q;
      key_raw[KEY_SELECT] = i_select & ~sel_q;
      key_raw[KEY_UP]     = up_evt;
      key_raw[KEY_DOWN]   = dn_evt;
      key_evt             = first_key(key_raw);
   end

   // The back edge in S_BAND_SEL already moves to S_IDLE, so the long-press timer only
   // counts cycles where back is held past its edge while in S_IDLE or S_BAND_SEL.
   assign hold_run = i_back & back_q & ((state_q == S_IDLE) | (state_q == S_BAND_SEL));
   assign hold_d   = hold_run ? hold_q + 24'd1 : 24'd0;
   assign flat_go  = hold_run && (hold_q == FLAT_HOLD - 24'd1);
   assign cur_gain = gain_q[band_q];

   always_comb begin
      state_d    = state_q;
      band_d     = band_q;
      gain_d     = gain_q;
      upd_vld_d  = upd_vld_q & ~i_upd_ready;
      upd_band_d = upd_band_q;
      upd_gain_d = upd_gain_q;
      flat_cnt_d = flat_cnt_q;
      case (state_q)
         S_INIT: begin
            if (i_init_done) state_d = S_IDLE;
         end
         S_IDLE, S_BAND_SEL: begin
            if (flat_go) begin
               state_d    = S_FLAT;
               flat_cnt_d = '0;
               for (int i = 0; i < NBAND; i++) gain_d[i] = '0;
            end else if (state_q == S_IDLE) begin
               if (key_evt[KEY_SELECT]) state_d = S_BAND_SEL;
            end else if (key_evt[KEY_BACK]) begin
               state_d = S_IDLE;
            end else if (key_evt[KEY_SELECT]) begin
               state_d = S_SET_GAIN;
            end else if (key_evt[KEY_UP]) begin
               if (band_q != BAND_LAST)  band_d = band_q + BW'(1);
               else if (BAND_WRAP)       band_d = '0;
            end else if (key_evt[KEY_DOWN]) begin
               if (band_q != '0)         band_d = band_q - BW'(1);
               else if (BAND_WRAP)       band_d = BAND_LAST;
            end
         end
         S_SET_GAIN: begin
            // A step needs an idle update port and a real change; otherwise it is dropped.
            if (key_evt[KEY_BACK]) begin
               state_d = S_BAND_SEL;
            end else if (!upd_vld_q) begin
               if (key_evt[KEY_UP] && (cur_gain < G_MAX)) begin
                  gain_d[band_q] = cur_gain + gain_t'(1);
                  upd_vld_d      = 1'b1;
                  upd_band_d     = band_q;
                  upd_gain_d     = cur_gain + gain_t'(1);
               end else if (key_evt[KEY_DOWN] && (cur_gain > G_MIN)) begin
                  gain_d[band_q] = cur_gain - gain_t'(1);
                  upd_vld_d      = 1'b1;
                  upd_band_d     = band_q;
                  upd_gain_d     = cur_gain - gain_t'(1);
               end
            end
         end
         S_FLAT: begin
            // Any update pending at entry completes first; flat updates then go out one per
            // handshake, and the last accept returns to idle.
            if (!upd_vld_q) begin
               if (flat_cnt_q < FLAT_END) begin
                  upd_vld_d  = 1'b1;
                  upd_band_d = BW'(flat_cnt_q);
                  upd_gain_d = '0;
                  flat_cnt_d = flat_cnt_q + FW'(1);
               end
            end else if (i_upd_ready && (flat_cnt_q == FLAT_END)) begin
               state_d = S_IDLE;
               band_d  = '0;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_INIT;
         band_q     <= '0;
         for (int i = 0; i < NBAND; i++) gain_q[i] <= '0;
         upd_vld_q  <= 1'b0;
         upd_band_q <= '0;
         upd_gain_q <= '0;
         sel_q      <= 1'b0;
         back_q     <= 1'b0;
         hold_q     <= 24'd0;
         flat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         band_q     <= band_d;
         gain_q     <= gain_d;
         upd_vld_q  <= upd_vld_d;
         upd_band_q <= upd_band_d;
         upd_gain_q <= upd_gain_d;
         sel_q      <= i_select;
         back_q     <= i_back;
         hold_q     <= hold_d;
         flat_cnt_q <= flat_cnt_d;
      end
   end

   assign o_init_start = (state_q == S_INIT);
   assign o_state      = state_q;
   assign o_band       = band_q;
   assign o_gain       = cur_gain;
   assign o_upd_valid  = upd_vld_q;
   assign o_upd_band   = upd_band_q;
   assign o_upd_gain   = upd_gain_q;

endmodule
